// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered sync/valid,
// line/frame strobes, pixel enable and a ce-qualified alignment delay line.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10,
  parameter int DELAY    = 2
) (
  input  logic          clk_25m,
  input  logic          rst,
  input  logic          ce,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          valid,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic          valid_d,
  output logic          hsync_d,
  output logic          vsync_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);
  localparam logic [2:0]    IDLE   = {1'b0, ~H_POL, ~V_POL};

  if ((64'd1 << CW) < 64'(H_TOTAL) ||
      (64'd1 << CW) < 64'(V_TOTAL)) begin : g_cw_chk
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  if (DELAY < 0 || DELAY > 7) begin : g_dly_chk
    $error("vga_timing_gen: DELAY must be 0..7");
  end

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          act_q, act_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ce) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Qualifiers decode the next position so they land with the coordinates.
  always_comb begin
    act_d = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
    hs_d  = (int'(x_d) >= HS_BEG && int'(x_d) < HS_END) ? H_POL : ~H_POL;
    vs_d  = (int'(y_d) >= VS_BEG && int'(y_d) < VS_END) ? V_POL : ~V_POL;
    ls_d  = (x_d == '0);
    fs_d  = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      x_q   <= X_LAST;
      y_q   <= Y_LAST;
      act_q <= 1'b0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else if (ce) begin
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign valid       = act_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  if (DELAY == 0) begin : g_nodly
    assign {valid_d, hsync_d, vsync_d} = {act_q, hs_q, vs_q};
  end else begin : g_dly
    logic [2:0] pipe_q [DELAY];

    always_ff @(posedge clk_25m) begin
      if (rst) begin
        for (int i = 0; i < DELAY; i++) pipe_q[i] <= IDLE;
      end else if (ce) begin
        pipe_q[0] <= {act_q, hs_q, vs_q};
        for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign {valid_d, hsync_d, vsync_d} = pipe_q[DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two geometries driven by shared random ce/rst,
// checked by a scoreboard fed from a raster-position reference model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hsw, hb;
    int va, vf, vsw, vb;
    bit hp, vp;
    int d;
  } geom_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic v, hs, vs, ls, fs, vd, hsd, vsd;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] pxa, pya;
  logic va, hsa, vsa, lsa, fsa, vda, hsda, vsda;
  logic [4:0] pxb, pyb;
  logic vb, hsb, vsb, lsb, fsb, vdb, hsdb, vsdb;

  vga_timing_gen dut_a (
    .clk_25m(clk), .rst(rst), .ce(ce),
    .pixel_x(pxa), .pixel_y(pya), .valid(va),
    .hsync(hsa), .vsync(vsa),
    .line_start(lsa), .frame_start(fsa),
    .valid_d(vda), .hsync_d(hsda), .vsync_d(vsda)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b1), .CW(5), .DELAY(0)
  ) dut_b (
    .clk_25m(clk), .rst(rst), .ce(ce),
    .pixel_x(pxb), .pixel_y(pyb), .valid(vb),
    .hsync(hsb), .vsync(vsb),
    .line_start(lsb), .frame_start(fsb),
    .valid_d(vdb), .hsync_d(hsdb), .vsync_d(vsdb)
  );

  geom_t g [2];
  int    pos [2];
  exp_t  cur [2];
  logic [2:0] hist_a [$];
  logic [2:0] hist_b [$];
  pair_t sb [$];

  int checks   = 0;
  int failures = 0;

  function automatic exp_t decode(input geom_t gg, input int p);
    exp_t e;
    int ht, x, y, h0, v0;
    ht = gg.ha + gg.hf + gg.hsw + gg.hb;
    x  = p % ht;
    y  = p / ht;
    h0 = gg.ha + gg.hf;
    v0 = gg.va + gg.vf;
    e    = '0;
    e.x  = 16'(x);
    e.y  = 16'(y);
    e.v  = (x < gg.ha) && (y < gg.va);
    e.hs = (x >= h0 && x < h0 + gg.hsw) ? gg.hp : !gg.hp;
    e.vs = (y >= v0 && y < v0 + gg.vsw) ? gg.vp : !gg.vp;
    e.ls = (x == 0);
    e.fs = (p == 0);
    return e;
  endfunction

  // History of undelayed triples since reset; entry 0 is the reset value.
  task automatic step(input int k, input bit r, input bit c);
    geom_t gg;
    int ht, vt, n;
    logic [2:0] idle, u, dl;
    gg   = g[k];
    ht   = gg.ha + gg.hf + gg.hsw + gg.hb;
    vt   = gg.va + gg.vf + gg.vsw + gg.vb;
    idle = {1'b0, !gg.hp, !gg.vp};
    if (r) begin
      pos[k] = ht * vt - 1;
      cur[k] = '0;
      cur[k].x  = 16'(ht - 1);
      cur[k].y  = 16'(vt - 1);
      cur[k].hs = !gg.hp;
      cur[k].vs = !gg.vp;
      if (k == 0) begin
        hist_a.delete();
        hist_a.push_back(idle);
      end else begin
        hist_b.delete();
        hist_b.push_back(idle);
      end
      {cur[k].vd, cur[k].hsd, cur[k].vsd} = idle;
    end else if (c) begin
      pos[k] = (pos[k] + 1) % (ht * vt);
      cur[k] = decode(gg, pos[k]);
      u  = {cur[k].v, cur[k].hs, cur[k].vs};
      dl = idle;
      if (k == 0) begin
        hist_a.push_back(u);
        n = hist_a.size() - 1;
        if (n >= gg.d) dl = hist_a[n - gg.d];
      end else begin
        hist_b.push_back(u);
        n = hist_b.size() - 1;
        if (n >= gg.d) dl = hist_b[n - gg.d];
      end
      {cur[k].vd, cur[k].hsd, cur[k].vsd} = dl;
    end
  endtask

  task automatic drive(input bit r, input bit c);
    pair_t p;
    @(negedge clk);
    rst = r;
    ce  = c;
    step(0, r, c);
    step(1, r, c);
    p.a = cur[0];
    p.b = cur[1];
    sb.push_back(p);
  endtask

  function automatic void cmp(input string nm, input exp_t act,
                              input exp_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s xy/flags actual=%0d,%0d,%b required=%0d,%0d,%b",
               nm, act.x, act.y,
               {act.v, act.hs, act.vs, act.ls, act.fs,
                act.vd, act.hsd, act.vsd},
               req.x, req.y,
               {req.v, req.hs, req.vs, req.ls, req.fs,
                req.vd, req.hsd, req.vsd});
    end
  endfunction

  initial begin : monitor
    pair_t e;
    exp_t  ga, gb;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ga = {6'd0, pxa, 6'd0, pya,
              va, hsa, vsa, lsa, fsa, vda, hsda, vsda};
        gb = {11'd0, pxb, 11'd0, pyb,
              vb, hsb, vsb, lsb, fsb, vdb, hsdb, vsdb};
        cmp("dutA", ga, e.a);
        cmp("dutB", gb, e.b);
      end
    end
  end

  initial begin : stim
    g[0] = '{ha:640, hf:16, hsw:96, hb:48,
             va:480, vf:10, vsw:2, vb:33,
             hp:1'b0, vp:1'b0, d:2};
    g[1] = '{ha:10, hf:2, hsw:3, hb:4,
             va:6, vf:1, vsw:2, vb:3,
             hp:1'b1, vp:1'b1, d:0};
    for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom_range(1)));
    for (int i = 0; i < 2500; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) drive(1'b0, $urandom_range(3) == 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom_range(1)));
    for (int i = 0; i < 3000; i++) drive(1'b0, 1'($urandom_range(1)));
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) drive(1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next-generation replacement for the fixed 640x480 scan counter. It produces pixel coordinates, active-video qualifier, and horizontal/vertical sync with configurable porches, sync widths and polarities. It also provides line/frame start strobes, a clock enable for running from a faster clock, and a configurable delay pipeline that aligns sync/valid with downstream RAM/ROM read latency. It sits between the pixel clock domain and the tank/map renderers, which consume `pixel_x`/`pixel_y` and drive RGB on `valid_d`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 0, vsync active level (0 = active-low)
- `CW`, 10, coordinate width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL), else elaboration error
- `DELAY`, 2, pipeline stages on delayed outputs, 0..7

Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).

- `clk_25m`  in  1  pixel (or faster) clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ce`  in  1  pixel advance enable; tie high for a native pixel clock
- `pixel_x`  out  CW  current column, 0..H_TOTAL-1
- `pixel_y`  out  CW  current line, 0..V_TOTAL-1
- `valid`  out  1  pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- `hsync`  out  1  horizontal sync at H_POL level when asserted
- `vsync`  out  1  vertical sync at V_POL level when asserted
- `line_start`  out  1  high for the cycle where pixel_x == 0
- `frame_start`  out  1  high for the cycle where pixel_x == 0 and pixel_y == 0
- `valid_d`, `hsync_d`, `vsync_d`  out  1 each  valid/hsync/vsync delayed DELAY ce-advances

## Operation
- Horizontal counter: on ce, increments; at H_TOTAL-1 wraps to 0 and advances the vertical counter.
- Vertical counter: advances only on horizontal wrap; at V_TOTAL-1 wraps to 0.
- hsync is asserted for pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise it is at !H_POL.
- vsync is asserted for pixel_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], spanning whole lines; otherwise it is at !V_POL.
- All outputs are registered (no decode glitches). valid/hsync/vsync/line_start/frame_start are decoded from the next-state counter, so they are cycle-aligned with the pixel_x/pixel_y they describe.
- Delay pipeline: DELAY-deep shift register of {valid, hsync, vsync}, shifting only on ce. With DELAY = 0, the `_d` outputs equal the undelayed outputs.
- ce low: every output and every pipeline stage holds its value. Strobes stay high if they were high; consumers qualify strobes with ce.

## Timing
- Reset (rst high at a rising edge):
  - pixel_x = H_TOTAL-1 and pixel_y = V_TOTAL-1, i.e. the last position of the frame.
  - valid = 0; hsync = !H_POL; vsync = !V_POL; line_start = 0; frame_start = 0.
  - All pipeline stages are set to valid 0 and inactive syncs.
- First ce cycle after rst deasserts: outputs show (0,0) with valid = 1, line_start = 1 and frame_start = 1.
- Reset mid-frame: takes effect at the next edge regardless of ce, and overrides ce.
- Latency: coordinates-to-qualifier latency is 0. The `_d` outputs lag by exactly DELAY ce-qualified cycles.
- Frame period: H_TOTAL*V_TOTAL ce cycles (420000 by default). Line period: H_TOTAL ce cycles.
- Simultaneous H and V wrap at (H_TOTAL-1, V_TOTAL-1) goes to (0,0) in one cycle, with both strobes high.

## Test plan
- Defaults, ce=1, reset released: the first cycle shows (0,0), valid=1 and frame_start=1. The next frame_start occurs exactly 420000 cycles later. The line_start spacing is 800.
- Defaults, line 0: hsync is low exactly for pixel_x 656..751 (96 cycles). valid drops at pixel_x=640. pixel_x reaches 799, then 0.
- Defaults, vsync: low for the whole of lines 490 and 491 (1600 cycles). High on lines 489 and 492. valid = 0 on lines 480..524.
- Polarity/geometry override (H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, H_POL=1, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, V_POL=1, CW=11):
  - hsync is high only for pixel_x 840..967.
  - vsync is high only for lines 601..604.
  - The frame is 1056*628 cycles.
- ce driven 1-in-4 on a 100 MHz clock:
  - Outputs change only on ce cycles.
  - The `_d` outputs with DELAY=2 match the undelayed signals from two ce-advances earlier.
  - The frame takes 1680000 clocks.
- Assert rst for 3 cycles at (300,200):
  - Outputs go to (799,524), valid=0 and syncs inactive.
  - The `_d` outputs are cleared.
  - Restart produces frame_start on the first ce after release.
